// File: rtl/multichannel_oversample_filter.sv
// Time-multiplexed multichannel oversampling averager.
// Each channel sums 2**osm samples that carry its tag, then emits the
// arithmetic-shifted average. After each output it discards cycle_delay
// samples. Because at most one sample arrives per cycle, one shared
// datapath serves every channel.
module multichannel_oversample_filter #(
  parameter int unsigned W_DATA    = 18,
  parameter int unsigned W_EP      = 16,
  parameter int unsigned W_OSM     = 4,
  parameter int unsigned N_CH      = 8,
  parameter int unsigned OSM_INIT  = 0,
  parameter int unsigned CDLY_INIT = 0,
  localparam int unsigned W_CHAN   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic signed [W_DATA-1:0] data_in,
  input  logic [W_CHAN-1:0]        data_chan_in,
  input  logic                     data_valid_in,
  input  logic [N_CH-1:0]          activate_in,
  input  logic [W_OSM-1:0]         osm_in,
  input  logic [W_EP-1:0]          cycle_delay_in,
  input  logic                     round_in,
  input  logic [N_CH-1:0]          update_en_in,
  input  logic                     update_in,
  output logic signed [W_DATA-1:0] data_out,
  output logic [W_CHAN-1:0]        data_chan_out,
  output logic                     data_valid_out
);

  localparam int unsigned MaxOs = (1 << W_OSM) - 1;
  localparam int unsigned WSum  = W_DATA + MaxOs;
  localparam int unsigned WCnt  = MaxOs + 1;

  typedef enum logic [1:0] {StIdle, StDelay, StSample} state_e;

  state_e                 st_q      [N_CH];
  state_e                 st_d      [N_CH];
  logic signed [WSum-1:0] acc_q     [N_CH];
  logic signed [WSum-1:0] acc_d     [N_CH];
  logic [WCnt-1:0]        cnt_q     [N_CH];
  logic [WCnt-1:0]        cnt_d     [N_CH];
  logic [W_EP-1:0]        dcnt_q    [N_CH];
  logic [W_EP-1:0]        dcnt_d    [N_CH];
  logic [W_OSM-1:0]       osm_q     [N_CH];
  logic [W_OSM-1:0]       osm_d     [N_CH];
  logic [W_EP-1:0]        cdly_q    [N_CH];
  logic [W_EP-1:0]        cdly_d    [N_CH];
  logic                   rnd_q     [N_CH];
  logic                   rnd_d     [N_CH];
  logic [W_OSM-1:0]       osm_win_q [N_CH];
  logic [W_OSM-1:0]       osm_win_d [N_CH];
  logic                   rnd_win_q [N_CH];
  logic                   rnd_win_d [N_CH];

  logic signed [W_DATA-1:0] dout_q, dout_d;
  logic [W_CHAN-1:0]        dchan_q, dchan_d;
  logic                     dvalid_q, dvalid_d;

  // Shared datapath signals for the channel addressed this cycle
  logic                   chan_ok;
  logic [W_CHAN-1:0]      sel_idx;
  logic [W_OSM-1:0]       sel_osm;
  logic                   sel_rnd;
  logic signed [WSum-1:0] sum_c;
  logic signed [WSum-1:0] rnd_c;
  logic signed [WSum-1:0] rsum_c;
  logic signed [WSum-1:0] avg_c;
  logic [WCnt-1:0]        cnt_inc_c;
  logic                   done_c;

  // Accumulate/average arithmetic for the tagged channel
  always_comb begin
    chan_ok   = data_valid_in && ({1'b0, data_chan_in} < (W_CHAN + 1)'(N_CH));
    sel_idx   = chan_ok ? data_chan_in : '0;
    sel_osm   = osm_win_q[sel_idx];
    sel_rnd   = rnd_win_q[sel_idx];
    sum_c     = acc_q[sel_idx] + WSum'(data_in);
    rnd_c     = (sel_rnd && (sel_osm != '0)) ? (WSum'(1) << (sel_osm - W_OSM'(1))) : '0;
    rsum_c    = sum_c + rnd_c;
    avg_c     = rsum_c >>> sel_osm;
    cnt_inc_c = cnt_q[sel_idx] + WCnt'(1);
    done_c    = (cnt_inc_c == (WCnt'(1) << sel_osm));
  end

  // Per-channel next state, parameter latching and output strobe
  always_comb begin
    dout_d   = dout_q;
    dchan_d  = dchan_q;
    dvalid_d = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      logic hit;
      hit          = chan_ok && (data_chan_in == W_CHAN'(c));
      st_d[c]      = st_q[c];
      acc_d[c]     = acc_q[c];
      cnt_d[c]     = cnt_q[c];
      dcnt_d[c]    = dcnt_q[c];
      osm_d[c]     = osm_q[c];
      cdly_d[c]    = cdly_q[c];
      rnd_d[c]     = rnd_q[c];
      osm_win_d[c] = osm_win_q[c];
      rnd_win_d[c] = rnd_win_q[c];

      if (update_in && update_en_in[c]) begin
        osm_d[c]  = osm_in;
        cdly_d[c] = cycle_delay_in;
        rnd_d[c]  = round_in;
      end

      unique case (st_q[c])
        StIdle: begin
          acc_d[c]  = '0;
          cnt_d[c]  = '0;
          dcnt_d[c] = '0;
          if (activate_in[c]) begin
            st_d[c]      = StSample;
            osm_win_d[c] = osm_d[c];
            rnd_win_d[c] = rnd_d[c];
          end
        end
        StSample: begin
          if (hit) begin
            if (done_c) begin
              if (activate_in[c]) begin
                dvalid_d = 1'b1;
                dout_d   = avg_c[W_DATA-1:0];
                dchan_d  = W_CHAN'(c);
              end
              acc_d[c]  = '0;
              cnt_d[c]  = '0;
              dcnt_d[c] = '0;
              // A zero delay skips DELAY so the very next sample is accumulated
              if (cdly_q[c] == '0) begin
                osm_win_d[c] = osm_d[c];
                rnd_win_d[c] = rnd_d[c];
              end else begin
                st_d[c] = StDelay;
              end
            end else begin
              acc_d[c] = sum_c;
              cnt_d[c] = cnt_inc_c;
            end
          end
        end
        StDelay: begin
          // Delay length is read live, so a shortened delay can end early
          if (hit) begin
            if (((W_EP + 1)'(dcnt_q[c]) + (W_EP + 1)'(1)) >= (W_EP + 1)'(cdly_q[c])) begin
              st_d[c]      = StSample;
              dcnt_d[c]    = '0;
              osm_win_d[c] = osm_d[c];
              rnd_win_d[c] = rnd_d[c];
            end else begin
              dcnt_d[c] = dcnt_q[c] + W_EP'(1);
            end
          end else if (dcnt_q[c] >= cdly_q[c]) begin
            st_d[c]      = StSample;
            dcnt_d[c]    = '0;
            osm_win_d[c] = osm_d[c];
            rnd_win_d[c] = rnd_d[c];
          end
        end
        default: st_d[c] = StIdle;
      endcase

      if (!activate_in[c]) begin
        st_d[c]   = StIdle;
        acc_d[c]  = '0;
        cnt_d[c]  = '0;
        dcnt_d[c] = '0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]      <= StIdle;
        acc_q[c]     <= '0;
        cnt_q[c]     <= '0;
        dcnt_q[c]    <= '0;
        osm_q[c]     <= W_OSM'(OSM_INIT);
        cdly_q[c]    <= W_EP'(CDLY_INIT);
        rnd_q[c]     <= 1'b0;
        osm_win_q[c] <= W_OSM'(OSM_INIT);
        rnd_win_q[c] <= 1'b0;
      end
      dout_q   <= '0;
      dchan_q  <= '0;
      dvalid_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        st_q[c]      <= st_d[c];
        acc_q[c]     <= acc_d[c];
        cnt_q[c]     <= cnt_d[c];
        dcnt_q[c]    <= dcnt_d[c];
        osm_q[c]     <= osm_d[c];
        cdly_q[c]    <= cdly_d[c];
        rnd_q[c]     <= rnd_d[c];
        osm_win_q[c] <= osm_win_d[c];
        rnd_win_q[c] <= rnd_win_d[c];
      end
      dout_q   <= dout_d;
      dchan_q  <= dchan_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign data_out       = dout_q;
  assign data_chan_out  = dchan_q;
  assign data_valid_out = dvalid_q;

endmodule
